// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: read pointers, empty/almost-empty flags and a prefetching output register.
// Define FIFO_RD_LEVEL_EN to expose the registered memory occupancy on rd_level.
module fifo_rd_ctrl #(
    parameter int data_width    = 8,
    parameter int ptr_width     = 9,
    parameter int aempty_thresh = 4
) (
    input  logic                  rclk,
    input  logic                  r_rst,
    input  logic [ptr_width:0]    rq2_wptr,
    input  logic [data_width-1:0] mem_rdata,
    output logic [ptr_width:0]    raddr,
    output logic [ptr_width:0]    rptr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  m_valid,
    output logic [data_width-1:0] m_data,
    input  logic                  m_ready,
    output logic [ptr_width:0]    rd_level
);

    localparam logic [ptr_width:0] ae_lim = (ptr_width + 1)'(aempty_thresh);

    logic [ptr_width:0] rbin;
    logic [ptr_width:0] rbin_next;
    logic [ptr_width:0] rgray_next;
    logic [ptr_width:0] wbin;
    logic [ptr_width:0] occ;
    logic               r_en;

    // Fetch whenever a word is available and the output slot is free or being drained.
    always_comb begin
        r_en       = !empty && (!m_valid || m_ready);
        rbin_next  = rbin + {{ptr_width{1'b0}}, r_en};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    always_comb begin
        wbin = '0;
        wbin[ptr_width] = rq2_wptr[ptr_width];
        for (int i = ptr_width - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ rq2_wptr[i];
        end
    end

    // Modular difference; the extra pointer bit lets a full memory read as depth.
    assign occ   = wbin - rbin_next;
    assign raddr = rbin;

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            rbin         <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            rbin         <= rbin_next;
            rptr         <= rgray_next;
            empty        <= (rgray_next == rq2_wptr);
            almost_empty <= (occ <= ae_lim);
        end
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (r_en) begin
            m_valid <= 1'b1;
            m_data  <= mem_rdata;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            rd_level <= '0;
        end else begin
            rd_level <= occ;
        end
    end
`else
    assign rd_level = '0;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the async FIFO, in the read clock domain; the reader counterpart to the write-side storage and write-pointer logic.
- Owns the binary read address and the Gray read pointer, and generates the empty and almost-empty flags against the synchronised write pointer.
- Prefetches words from the combinational memory read port into a registered valid/ready output stage for the downstream consumer.

Parameters:
data_width, 8, width of each stored word
ptr_width, 9, memory address bits; FIFO depth is 2**ptr_width; pointers are ptr_width+1 bits
aempty_thresh, 4, almost_empty asserts when occupancy <= this value

Ports:
rclk  input  1  read clock; all state changes on posedge
r_rst  input  1  asynchronous active-high reset
rq2_wptr  input  ptr_width+1  write pointer, Gray code, already 2-flop synchronised into rclk
mem_rdata  input  data_width  combinational memory read data at raddr
raddr  output  ptr_width+1  binary read pointer; memory uses the low ptr_width bits
rptr  output  ptr_width+1  Gray read pointer, registered, sent to the write domain
empty  output  1  FIFO memory empty (registered)
almost_empty  output  1  occupancy <= aempty_thresh (registered)
m_valid  output  1  output register holds a word
m_data  output  data_width  output word
m_ready  input  1  consumer accepts m_data when m_valid and m_ready are both 1
rd_level  output  ptr_width+1  memory occupancy (see Optional Feature)

Behaviour:
- Reset (async on r_rst rising, held while high):
  - raddr=0, rptr=0, empty=1, almost_empty=1, m_valid=0, m_data=0, rd_level=0.
- Internal read strobe, r_en = !empty && (!m_valid || m_ready).
- Pointer update:
  - rbin_next = rbin + r_en, modulo 2**(ptr_width+1).
  - rgray_next = (rbin_next>>1) ^ rbin_next.
  - On posedge: raddr <= rbin_next and rptr <= rgray_next.
- Empty flag:
  - empty <= (rgray_next == rq2_wptr), i.e. evaluated on the next pointer, so the FIFO is never read past the write pointer.
- Output register:
  - On r_en: m_data <= mem_rdata (the word at the current raddr); m_valid <= 1.
  - Else if m_valid && m_ready: m_valid <= 0; m_data holds its value.
  - When r_en and m_ready coincide, the old word is consumed and the new word is loaded in the same cycle, with no bubble.
- Latency:
  - Write pointer becomes visible on rq2_wptr at edge N -> empty=0 after edge N.
  - m_valid=1 after edge N+1.
  - Sustained throughput is 1 word/cycle while the FIFO is non-empty and m_ready=1.
- Occupancy:
  - wbin = Gray-to-binary(rq2_wptr); occ = (wbin - rbin_next) mod 2**(ptr_width+1), range 0..2**ptr_width.
  - almost_empty <= (occ <= aempty_thresh).
  - occ excludes the word held in the output register.
- Wrap-around:
  - raddr wraps from 2**(ptr_width+1)-1 to 0; the MSB toggle on wrap is what distinguishes full from empty on the write side.
  - The low ptr_width bits wrap every depth words.
- Backpressure:
  - m_valid && !m_ready -> m_data, m_valid, raddr and rptr all hold, even if new data arrives.
- Consumer misuse:
  - m_ready high while m_valid=0 has no effect.
- rq2_wptr behaviour:
  - rq2_wptr may jump by more than 1 between cycles (bursty write domain); occupancy and empty must still be correct.
  - A stale rq2_wptr only makes the FIFO look emptier than it is; this is conservative and safe.
- Reset mid-operation:
  - Any word in the output register is discarded and the pointers return to 0.
  - The write side is reset in the same system reset event.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN
- Defined: rd_level <= occ each cycle (registered, same timing as almost_empty), for debug and flow-control visibility.
- Undefined: rd_level tied to 0 and its register is not instantiated; almost_empty logic is unchanged.

Test Plan:
- Reset check: hold r_rst=1 for 3 cycles, rq2_wptr=0 -> empty=1, almost_empty=1, m_valid=0, raddr=0, rptr=0; release -> all unchanged.
- Single word: mem holds 0xA5 at address 0, rq2_wptr steps 0->1 -> empty=0 next edge, m_valid=1 with m_data=0xA5 one edge later, raddr=1; with m_ready=1 -> m_valid=0 and empty=1 the following cycle.
- Streaming: preload addresses 0..15 with their index, rq2_wptr jumps to Gray(16), m_ready=1 -> m_data=0x00..0x0F on consecutive cycles with no gaps; almost_empty asserts once occ<=4.
- Backpressure: 3 words available, m_ready=0 for 5 cycles -> m_valid=1, m_data=first word, raddr=1 held; then m_ready=1 -> remaining 2 words delivered back-to-back.
- Wrap: stream 2**ptr_width+2 = 514 words -> raddr passes 511->512 (MSB set) and 1023->0 across a second test run; rptr equals the Gray code of raddr every cycle; data order is intact.
- Mid-burst reset: assert r_rst asynchronously while m_valid=1 and occ=7 -> outputs return to their reset values immediately, without waiting for a clock edge.
- Level feature (FIFO_RD_LEVEL_EN defined): after the 16-word preload with m_ready=0 -> rd_level=15 (one word in the output register).
- Level feature (FIFO_RD_LEVEL_EN undefined): same stimulus -> rd_level=0.
